// File: rtl/kb_event_if.sv
// CPU-side keyboard register interface: event pop/clear strobes and FIFO status.
interface kb_event_if;
  localparam int unsigned KEY_W = 10;

  logic             rd_key_code;
  logic             clr_ovf;
  logic [KEY_W-1:0] key_code;
  logic             kb_buf_empty;
  logic             kb_buf_full;
  logic             kb_ovf;

  // CPU / bench side
  modport master (
    output rd_key_code, clr_ovf,
    input  key_code, kb_buf_empty, kb_buf_full, kb_ovf
  );

  // Keyboard event decoder side
  modport slave (
    input  rd_key_code, clr_ovf,
    output key_code, kb_buf_empty, kb_buf_full, kb_ovf
  );
endinterface

// File: rtl/kb_event.sv
// PS/2 keyboard event decoder: receiver, scan-code sequencer and event FIFO.

// PS/2 serial receiver: deglitches ps2c and shifts one 11-bit frame per byte.
module ps2_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_done_tick,
  output logic [7:0] dout
);
  localparam int unsigned FILT_W  = 8;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [0:0] {RX_IDLE, RX_DPS} rx_state_e;

  rx_state_e          state_q, state_d;
  logic [FILT_W-1:0]  filter_q, filter_d;
  logic               f_ps2c_q, f_ps2c_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [FRAME_W-1:0] b_q, b_d;
  logic               done_q, done_d;
  logic               fall_edge;

  // Register update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
      n_q      <= '0;
      b_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
      n_q      <= n_d;
      b_q      <= b_d;
      done_q   <= done_d;
    end
  end

  // Clock deglitch, falling-edge detect and frame shift sequencing
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    b_d      = b_q;
    done_d   = 1'b0;
    filter_d = {ps2c, filter_q[FILT_W-1:1]};
    if (filter_q == {FILT_W{1'b1}}) begin
      f_ps2c_d = 1'b1;
    end else if (filter_q == {FILT_W{1'b0}}) begin
      f_ps2c_d = 1'b0;
    end else begin
      f_ps2c_d = f_ps2c_q;
    end
    fall_edge = f_ps2c_q & ~f_ps2c_d;

    unique case (state_q)
      RX_IDLE: begin
        if (fall_edge && rx_en) begin
          b_d     = {ps2d, b_q[FRAME_W-1:1]};
          n_d     = CNT_W'(9);
          state_d = RX_DPS;
        end
      end
      RX_DPS: begin
        if (fall_edge) begin
          b_d = {ps2d, b_q[FRAME_W-1:1]};
          if (n_q == '0) begin
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            n_d = n_q - CNT_W'(1);
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Start bit has been shifted out; the low byte is the data
  assign rx_done_tick = done_q;
  assign dout         = b_q[7:0];
endmodule

// Synchronous FIFO; writes when full and reads when empty are ignored.
module fifo #(
  parameter int unsigned B = 10,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data
);
  localparam int unsigned DEPTH = 2 ** W;

  logic [B-1:0] mem_q [DEPTH];
  logic [B-1:0] mem_d [DEPTH];
  logic [W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [W-1:0] w_succ, r_succ;
  logic         full_q, full_d, empty_q, empty_d;
  logic         wr_ok, rd_ok;

  // Storage, pointers and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Pointer advance and flag update; pointers wrap naturally at DEPTH
  always_comb begin
    mem_d   = mem_q;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    w_succ  = w_ptr_q + W'(1);
    r_succ  = r_ptr_q + W'(1);
    wr_ok   = wr & ~full_q;
    rd_ok   = rd & ~empty_q;
    if (wr_ok) begin
      mem_d[w_ptr_q] = w_data;
    end
    unique case ({wr_ok, rd_ok})
      2'b10: begin
        w_ptr_d = w_succ;
        empty_d = 1'b0;
        full_d  = (w_succ == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_succ;
        full_d  = 1'b0;
        empty_d = (r_succ == w_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_succ;
        r_ptr_d = r_succ;
      end
      default: ;
    endcase
  end

  assign empty  = empty_q;
  assign full   = full_q;
  assign r_data = mem_q[r_ptr_q];
endmodule

// Top: decodes scan-code sequences into {ext, brk, code} events.
module kb_event #(
  parameter int unsigned W_SIZE        = 2,
  parameter int unsigned REPORT_MAKE   = 1,
  parameter int unsigned FILTER_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  kb_event_if.slave  cpu
);
  localparam int unsigned KEY_W  = 10;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CODE_W-1:0] C_EXT    = 8'hE0;
  localparam logic [CODE_W-1:0] C_BRK    = 8'hF0;
  localparam logic [CODE_W-1:0] C_PAUSE  = 8'hE1;
  localparam logic [CODE_W-1:0] C_FSHIFT = 8'h12;

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W:0]   held_q, held_d;
  logic              held_vld_q, held_vld_d;
  logic              ovf_q, ovf_d;

  logic              scan_done_tick;
  logic [CODE_W-1:0] scan_out;
  logic              push_c;
  logic [KEY_W-1:0]  ev_c;
  logic              mk_req, mk_ext, bk_req, bk_ext, repeat_hit;

  ps2_rx u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_en        (1'b1),
    .ps2d         (ps2d),
    .ps2c         (ps2c),
    .rx_done_tick (scan_done_tick),
    .dout         (scan_out)
  );

  fifo #(.B(KEY_W), .W(W_SIZE)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .rd     (cpu.rd_key_code),
    .wr     (push_c),
    .w_data (ev_c),
    .empty  (cpu.kb_buf_empty),
    .full   (cpu.kb_buf_full),
    .r_data (cpu.key_code)
  );

  // Sequencer state, pause byte counter, held key and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  // Prefix decoding, make/break event generation and overflow tracking
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    ovf_d      = ovf_q;
    push_c     = 1'b0;
    ev_c       = '0;
    mk_req     = 1'b0;
    mk_ext     = 1'b0;
    bk_req     = 1'b0;
    bk_ext     = 1'b0;
    repeat_hit = 1'b0;

    if (scan_done_tick) begin
      unique case (state_q)
        S_IDLE: begin
          case (scan_out)
            C_EXT:   state_d = S_EXT;
            C_BRK:   state_d = S_BRK;
            C_PAUSE: begin
              state_d = S_PAUSE;
              cnt_d   = CNT_W'(7);
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
            default: mk_req = 1'b1;
          endcase
        end
        S_EXT: begin
          if (scan_out == C_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d = S_IDLE;
            if (scan_out != C_FSHIFT) begin
              mk_req = 1'b1;
              mk_ext = 1'b1;
            end
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          bk_req  = 1'b1;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (scan_out != C_FSHIFT) begin
            bk_req = 1'b1;
            bk_ext = 1'b1;
          end
        end
        S_PAUSE: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            if (REPORT_MAKE != 0) begin
              push_c = 1'b1;
              ev_c   = {2'b00, C_PAUSE};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Held key is tracked even when makes are not reported or get dropped
    repeat_hit = (FILTER_REPEAT != 0) && held_vld_q && (held_q == {mk_ext, scan_out});
    if (mk_req && !repeat_hit) begin
      held_d     = {mk_ext, scan_out};
      held_vld_d = 1'b1;
      if (REPORT_MAKE != 0) begin
        push_c = 1'b1;
        ev_c   = {mk_ext, 1'b0, scan_out};
      end
    end

    if (bk_req) begin
      push_c = 1'b1;
      ev_c   = {bk_ext, 1'b1, scan_out};
      if (held_vld_q && (held_q == {bk_ext, scan_out})) begin
        held_vld_d = 1'b0;
      end
    end

    // Set beats clear when both happen together
    if (cpu.clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (push_c && cpu.kb_buf_full) begin
      ovf_d = 1'b1;
    end
  end

  assign cpu.kb_ovf = ovf_q;
endmodule

// File: tb/tb_kb_event.sv
// Bench for kb_event: three configurations share one PS/2 stimulus stream.
module tb_kb_event;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic reset;
  logic ps2d, ps2c;

  int checks = 0;
  int errors = 0;

  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  logic [9:0] q_c[$];
  bit rd_en_a = 1'b1;
  bit rd_en_b = 1'b1;
  bit rd_en_c = 1'b1;

  kb_event_if if_a ();
  kb_event_if if_b ();
  kb_event_if if_c ();

  kb_event #(.W_SIZE(2), .REPORT_MAKE(1), .FILTER_REPEAT(1)) dut_a (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .cpu(if_a));
  kb_event #(.W_SIZE(2), .REPORT_MAKE(1), .FILTER_REPEAT(0)) dut_b (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .cpu(if_b));
  kb_event #(.W_SIZE(1), .REPORT_MAKE(1), .FILTER_REPEAT(1)) dut_c (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .cpu(if_c));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached", name);
  endtask

  // Scoreboard monitors: pop one event per DUT whenever its FIFO is non-empty
  always @(negedge clk) begin
    if (reset !== 1'b1 && rd_en_a && if_a.kb_buf_empty === 1'b0) begin
      if (q_a.size() == 0) check("a_unexpected_event", 32'(if_a.key_code), 32'h3FF_FFFF);
      else check("a_event", 32'(if_a.key_code), 32'(q_a.pop_front()));
      if_a.rd_key_code = 1'b1;
    end else if_a.rd_key_code = 1'b0;
  end

  always @(negedge clk) begin
    if (reset !== 1'b1 && rd_en_b && if_b.kb_buf_empty === 1'b0) begin
      if (q_b.size() == 0) check("b_unexpected_event", 32'(if_b.key_code), 32'h3FF_FFFF);
      else check("b_event", 32'(if_b.key_code), 32'(q_b.pop_front()));
      if_b.rd_key_code = 1'b1;
    end else if_b.rd_key_code = 1'b0;
  end

  always @(negedge clk) begin
    if (reset !== 1'b1 && rd_en_c && if_c.kb_buf_empty === 1'b0) begin
      if (q_c.size() == 0) check("c_unexpected_event", 32'(if_c.key_code), 32'h3FF_FFFF);
      else check("c_event", 32'(if_c.key_code), 32'(q_c.pop_front()));
      if_c.rd_key_code = 1'b1;
    end else if_c.rd_key_code = 1'b0;
  end

  task automatic exp_all(input logic [9:0] v);
    q_a.push_back(v); q_b.push_back(v); q_c.push_back(v);
  endtask

  task automatic exp_ac(input logic [9:0] v);
    q_a.push_back(v); q_c.push_back(v);
  endtask

  // One PS/2 frame: start, 8 data LSB first, odd parity, stop
  task automatic send_byte(input logic [7:0] b);
    logic [10:0] frame;
    frame = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); ps2d = frame[i];
      repeat (HALF) @(negedge clk); ps2c = 1'b0;
      repeat (HALF) @(negedge clk); ps2c = 1'b1;
    end
    repeat (HALF) @(negedge clk); ps2d = 1'b1;
  endtask

  task automatic drain(input string tag);
    repeat (40) @(negedge clk);
    check({tag, "_a_drained"}, 32'(q_a.size()), 0);
    check({tag, "_b_drained"}, 32'(q_b.size()), 0);
    check({tag, "_c_drained"}, 32'(q_c.size()), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a_empty"}, 32'(if_a.kb_buf_empty), 1);
    check({tag, "_a_full"},  32'(if_a.kb_buf_full), 0);
    check({tag, "_a_ovf"},   32'(if_a.kb_ovf), 0);
    check({tag, "_b_empty"}, 32'(if_b.kb_buf_empty), 1);
    check({tag, "_c_empty"}, 32'(if_c.kb_buf_empty), 1);
    check({tag, "_c_full"},  32'(if_c.kb_buf_full), 0);
    check({tag, "_c_ovf"},   32'(if_c.kb_ovf), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Empty must still be high on the tick cycle and low one cycle later
  task automatic watch_first_push();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (dut_a.scan_done_tick === 1'b1) begin
        seen = 1'b1;
        check("a_empty_on_tick", 32'(if_a.kb_buf_empty), 1);
        @(negedge clk);
        check("a_empty_after_tick", 32'(if_a.kb_buf_empty), 0);
      end
    end
    if (!seen) fail_now("a_first_tick_timeout");
  endtask

  // Assert clr_ovf exactly in the cycle a dropped push happens
  task automatic clr_on_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (dut_c.scan_done_tick === 1'b1) begin
        seen = 1'b1;
        if_c.clr_ovf = 1'b1;
        @(negedge clk);
        if_c.clr_ovf = 1'b0;
      end
    end
    if (!seen) fail_now("c_tick_timeout");
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ps2d = 1'b1; ps2c = 1'b1;
    if_a.clr_ovf = 1'b0; if_b.clr_ovf = 1'b0; if_c.clr_ovf = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");
    repeat (20) @(negedge clk);

    // A press and release
    exp_all(10'h01C); exp_all(10'h11C);
    fork
      send_byte(8'h1C);
      watch_first_push();
    join
    send_byte(8'hF0); send_byte(8'h1C);
    drain("a_key");

    // Extended up arrow, then fake shift around End
    exp_all(10'h275); exp_all(10'h375); exp_all(10'h27C);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'h7C);
    drain("ext");

    // Typematic repeat: filtered vs unfiltered
    exp_ac(10'h01C); exp_ac(10'h11C); exp_ac(10'h01C);
    q_b.push_back(10'h01C); q_b.push_back(10'h01C); q_b.push_back(10'h01C);
    q_b.push_back(10'h11C); q_b.push_back(10'h01C);
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
    drain("repeat");

    // Overflow of the two-deep configuration
    rd_en_c = 1'b0;
    q_a.push_back(10'h015); q_a.push_back(10'h01D); q_a.push_back(10'h024); q_a.push_back(10'h02D);
    q_b.push_back(10'h015); q_b.push_back(10'h01D); q_b.push_back(10'h024); q_b.push_back(10'h02D);
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
    repeat (20) @(negedge clk);
    check("c_full", 32'(if_c.kb_buf_full), 1);
    check("c_ovf_set", 32'(if_c.kb_ovf), 1);
    check("c_head", 32'(if_c.key_code), 32'h015);
    check("a_no_ovf", 32'(if_a.kb_ovf), 0);
    repeat (10) @(negedge clk);
    check("c_ovf_sticky", 32'(if_c.kb_ovf), 1);
    if_c.clr_ovf = 1'b1;
    @(negedge clk); if_c.clr_ovf = 1'b0;
    check("c_ovf_cleared", 32'(if_c.kb_ovf), 0);
    q_a.push_back(10'h035); q_b.push_back(10'h035);
    fork
      send_byte(8'h35);
      clr_on_tick();
    join
    check("c_ovf_set_wins", 32'(if_c.kb_ovf), 1);
    check("c_still_full", 32'(if_c.kb_buf_full), 1);
    if_c.clr_ovf = 1'b1;
    @(negedge clk); if_c.clr_ovf = 1'b0;
    check("c_ovf_cleared2", 32'(if_c.kb_ovf), 0);
    q_c.push_back(10'h015); q_c.push_back(10'h01D);
    rd_en_c = 1'b1;
    drain("ovf");
    check("c_empty_after_pops", 32'(if_c.kb_buf_empty), 1);
    check("c_not_full_after_pops", 32'(if_c.kb_buf_full), 0);

    // Pause sequence yields one event, then decoding resumes
    exp_all(10'h0E1); exp_all(10'h01C);
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h1C);
    drain("pause");

    // Reset between prefix and code drops the prefix; ack bytes are ignored
    send_byte(8'hE0);
    pulse_reset();
    check_reset_state("midseq_reset");
    repeat (20) @(negedge clk);
    exp_all(10'h075);
    send_byte(8'h75);
    send_byte(8'hAA); send_byte(8'hFA);
    drain("after_reset");
    check("final_a_empty", 32'(if_a.kb_buf_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kb_event.md
Name: kb_event

Overview:
- Parametrised PS/2 keyboard event decoder; next generation of the break-code-only keyboard front end.
- Reports both make and break events, with extended (E0) prefixes and the Pause (E1) sequence.
- Optional typematic-repeat filter; event FIFO depth set by parameter; sticky overflow flag.
- Sits between the PS/2 pins and the CPU keyboard register. Instantiates the existing ps2_rx (rx_en tied 1) and fifo (B=10, W=W_SIZE).

Parameters:
- W_SIZE, 2, event FIFO holds 2**W_SIZE words.
- REPORT_MAKE, 1, 1 = push make events; 0 = push break events only.
- FILTER_REPEAT, 1, 1 = drop repeated make of the currently held key.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps2d  in  1  PS/2 data line.
- ps2c  in  1  PS/2 clock line.
- rd_key_code  in  1  pop one event; ignored when kb_buf_empty=1.
- clr_ovf  in  1  clear overflow flag.
- key_code  out  10  head event {ext, brk, code[7:0]}; valid when kb_buf_empty=0.
- kb_buf_empty  out  1  FIFO empty.
- kb_buf_full  out  1  FIFO full.
- kb_ovf  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high. Every register, including those inside ps2_rx and fifo, clears on a clk edge with reset=1.
- Reset values: kb_buf_empty=1, kb_buf_full=0, kb_ovf=0, FSM=IDLE, held-key register invalid, skip counter=0.
- Byte input: each scan_done_tick delivers one byte b = scan_out. The FSM advances only on a tick.
- FSM states and transitions:
  - IDLE: b=E0 -> EXT; b=F0 -> BRK; b=E1 -> PAUSE with cnt=7; b in {00,AA,EE,FA,FE,FF} -> discard, stay; otherwise make event {0,0,b}.
  - EXT: b=F0 -> EXT_BRK; b=12 -> discard (fake shift) -> IDLE; otherwise make event {1,0,b} -> IDLE.
  - BRK: break event {0,1,b} -> IDLE.
  - EXT_BRK: b=12 -> discard -> IDLE; otherwise break event {1,1,b} -> IDLE.
  - PAUSE: cnt decrements per byte. On the byte that brings cnt to 0: push {0,0,E1} (subject to REPORT_MAKE; the repeat filter does not apply) -> IDLE.
- Make events:
  - Pushed only if REPORT_MAKE=1.
  - If FILTER_REPEAT=1 and {ext,code} equals the valid held-key register, the event is dropped silently. This is not an overflow.
  - Otherwise the held-key register loads {ext,code}, valid, even if the event is dropped for FIFO-full.
- Break events:
  - Always pushed.
  - If {ext,code} matches the held key, the held-key register is invalidated.
- Push timing: push (fifo wr) is Mealy, asserted in the same cycle as the final byte's scan_done_tick. The event is visible at key_code with kb_buf_empty=0 on the next cycle.
- FIFO-full boundary:
  - A push with kb_buf_full=1 in that cycle is dropped and sets kb_ovf, even if rd_key_code=1 in the same cycle.
  - The FSM still advances normally.
- Overflow flag:
  - kb_ovf stays set until clr_ovf=1.
  - Set and clear in the same cycle: set wins.
- Empty boundary: rd_key_code with kb_buf_empty=1 has no effect. Pointers wrap modulo 2**W_SIZE.
- Reset mid-sequence (e.g. after E0 or F0): prefix state is lost and the FSM returns to IDLE. The next byte is decoded fresh.

Test Plan:
- Send 1C, F0, 1C (A press/release) -> FIFO holds 01C then 11C in order; kb_buf_empty falls one cycle after the first 1C tick.
- Send E0 75, E0 F0 75 (up arrow) -> events 275 then 375. Send E0 12 E0 7C -> only 27C; fake shift 12 discarded.
- FILTER_REPEAT=1: send 1C,1C,1C,F0,1C,1C -> events 01C,11C,01C. With FILTER_REPEAT=0, the same stimulus gives 01C,01C,01C,11C,01C.
- W_SIZE=1, no reads, send 4 make codes 15,1D,24,2D -> FIFO holds 015,01D; kb_buf_full=1; kb_ovf=1. Then pulse clr_ovf -> kb_ovf=0; pop twice -> kb_buf_empty=1.
- Send E1 14 77 E1 F0 14 F0 77 (Pause) -> exactly one event 0E1. A following 1C -> 01C.
- Send E0, assert reset one cycle, then send 75 -> event 075 (no ext bit). Send AA, FA -> no events.
